// File: rtl/snn_pkg.sv
// Shared defaults and arithmetic helpers for the leaky integrate-and-fire layer.
// Optional refractory behaviour is enabled with the SNN_REFRACTORY_EN macro.
package snn_pkg;

   // Default layer configuration
   localparam int SNN_N_CH       = 3;
   localparam int SNN_DATA_W     = 8;
   localparam int SNN_MEM_W      = 12;
   localparam int SNN_THRESH     = 100;
   localparam int SNN_LEAK_SHIFT = 3;
   localparam int SNN_WIN_LEN    = 16;
   localparam int SNN_CNT_W      = 8;
   localparam int SNN_REFRAC_CYC = 2;

   // Adds two unsigned operands and clamps the result to the largest value
   // representable in 'width' bits. The operands are carried in a 32-bit
   // container so one helper serves any membrane width below 32 bits; the
   // caller keeps the low 'width' bits of the returned value.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          width);
      logic [32:0] sum;
      logic [31:0] max_val;
      sum = {1'b0, a} + {1'b0, b};
      if (width >= 32) begin
         max_val = 32'hFFFF_FFFF;
      end else begin
         max_val = (32'd1 << width) - 32'd1;
      end
      if (sum > {1'b0, max_val}) begin
         return max_val;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire channel: membrane with leak and threshold,
// reset-to-zero on firing, saturating spike counter for the current window.
// With SNN_REFRACTORY_EN defined the channel ignores REFRAC_CYC valid samples
// after each spike.
module snn_lif_neuron
   import snn_pkg::*;
#(
   parameter int DATA_W     = SNN_DATA_W,
   parameter int MEM_W      = SNN_MEM_W,
   parameter int THRESH     = SNN_THRESH,
   parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
   parameter int CNT_W      = SNN_CNT_W,
   parameter int REFRAC_CYC = SNN_REFRAC_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   input  logic              win_last,
   output logic              spike,
   output logic [CNT_W-1:0]  win_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [MEM_W-1:0] v;
   logic [MEM_W-1:0] leaked;
   logic [MEM_W-1:0] v_next;
   logic [31:0]      sum_sat;
   logic             fire;
   logic             refrac_active;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // Next membrane value, firing decision and the window count that includes
   // this sample's spike (the top captures it on the last sample of a window)
   always_comb begin
      leaked    = v - (v >> LEAK_SHIFT);
      sum_sat   = sat_add(32'(leaked), 32'(data), MEM_W);
      v_next    = sum_sat[MEM_W-1:0];
      fire      = valid && !refrac_active && (sum_sat >= 32'(THRESH));
      cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      win_count = fire ? cnt_inc : cnt;
   end

   // Membrane integrates only on valid samples and drops to zero when the
   // neuron fires or is refractory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else if (valid) begin
         if (refrac_active || fire) begin
            v <= '0;
         end else begin
            v <= v_next;
         end
      end
   end

   // Spike flag is a one-cycle registered copy of the firing decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike <= 1'b0;
      end else begin
         spike <= fire;
      end
   end

   // Window spike counter saturates and restarts after the window's last sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (valid) begin
         if (win_last) begin
            cnt <= '0;
         end else begin
            cnt <= win_count;
         end
      end
   end

`ifdef SNN_REFRACTORY_EN
   localparam int RC_W = (REFRAC_CYC < 2) ? 1 : $clog2(REFRAC_CYC + 1);

   logic [RC_W-1:0] refrac;

   assign refrac_active = (refrac != '0);

   // Refractory countdown consumes one valid sample per step after a spike
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refrac <= '0;
      end else if (valid) begin
         if (refrac_active) begin
            refrac <= refrac - 1'b1;
         end else if (fire) begin
            refrac <= RC_W'(REFRAC_CYC);
         end
      end
   end
`else
   assign refrac_active = 1'b0;

   // The refractory length only matters when the feature is built in
   if (REFRAC_CYC < 0) begin : g_refrac_check
      $error("REFRAC_CYC must not be negative");
   end
`endif

endmodule

// File: rtl/snn_lif_layer.sv
// Layer of N_CH leaky integrate-and-fire neurons with windowed spike-rate
// readout. The window counter, o_valid pulse and o_data capture live here;
// per-channel membrane and counting live in snn_lif_neuron.
// Optional feature macro: SNN_REFRACTORY_EN (refractory period per channel).
module snn_lif_layer
   import snn_pkg::*;
#(
   parameter int N_CH       = SNN_N_CH,
   parameter int DATA_W     = SNN_DATA_W,
   parameter int MEM_W      = SNN_MEM_W,
   parameter int THRESH     = SNN_THRESH,
   parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
   parameter int WIN_LEN    = SNN_WIN_LEN,
   parameter int CNT_W      = SNN_CNT_W,
   parameter int REFRAC_CYC = SNN_REFRAC_CYC
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_valid,
   input  logic [N_CH*DATA_W-1:0] i_data,
   output logic [N_CH-1:0]        o_spike,
   output logic [N_CH*CNT_W-1:0]  o_data,
   output logic                   o_valid
);

   localparam int WC_W = (WIN_LEN <= 2) ? 1 : $clog2(WIN_LEN);

   logic [WC_W-1:0]         win_cnt;
   logic                    win_last;
   logic [N_CH*CNT_W-1:0]   win_counts;

   if (WIN_LEN < 2) begin : g_win_check
      $error("WIN_LEN must be at least 2");
   end

   assign win_last = i_valid && (win_cnt == WC_W'(WIN_LEN - 1));

   // Counts valid samples within the window and wraps after the last one
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         win_cnt <= '0;
      end else if (i_valid) begin
         if (win_last) begin
            win_cnt <= '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
         end
      end
   end

   // Publishes the completed window's counts and pulses o_valid for one cycle
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= win_last;
         if (win_last) begin
            o_data <= win_counts;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_neuron
      snn_lif_neuron #(
         .DATA_W     (DATA_W),
         .MEM_W      (MEM_W),
         .THRESH     (THRESH),
         .LEAK_SHIFT (LEAK_SHIFT),
         .CNT_W      (CNT_W),
         .REFRAC_CYC (REFRAC_CYC)
      ) u_neuron (
         .clk       (i_clk),
         .rst_n     (i_rstn),
         .valid     (i_valid),
         .data      (i_data[k*DATA_W +: DATA_W]),
         .win_last  (win_last),
         .spike     (o_spike[k]),
         .win_count (win_counts[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Self-checking bench for snn_lif_layer: a sample-level model of the layer,
// a per-cycle compare process and directed scenarios with literal expectations.
// A second instance with CNT_W=3 exercises counter saturation.
// Build with SNN_REFRACTORY_EN defined to cover the refractory variant.
module tb_snn_lif_layer;

   localparam int N_CH       = 3;
   localparam int DATA_W     = 8;
   localparam int CNT_W      = 8;
   localparam int CNT_W_S    = 3;
   localparam int WIN_LEN    = 16;
   localparam int THRESH     = 100;
   localparam int LEAK_SHIFT = 3;
   localparam int MEM_MAX    = 4095;
`ifdef SNN_REFRACTORY_EN
   localparam int REFRAC     = 2;
   localparam int PRE_N      = 8;
   localparam int PRE_MASK   = 32'h84;
   localparam int WIN_MASK   = 32'h1084;
   localparam int CONST_CNT  = 3;
   localparam int MIX_CH2    = 6;
   localparam int MIX_CH2_S  = 6;
`else
   localparam int REFRAC     = 0;
   localparam int PRE_N      = 6;
   localparam int PRE_MASK   = 32'h24;
   localparam int WIN_MASK   = 32'h4924;
   localparam int CONST_CNT  = 5;
   localparam int MIX_CH2    = 16;
   localparam int MIX_CH2_S  = 7;
`endif

   logic                       clk = 1'b0;
   logic                       rstn = 1'b1;
   logic                       valid = 1'b0;
   logic [N_CH*DATA_W-1:0]     data = '0;
   logic [N_CH-1:0]            spike;
   logic [N_CH-1:0]            spike_s;
   logic [N_CH*CNT_W-1:0]      odata;
   logic [N_CH*CNT_W_S-1:0]    odata_s;
   logic                       ovalid;
   logic                       ovalid_s;

   int errors = 0;
   int checks = 0;

   // model state
   int   mv [N_CH];
   int   mcnt [N_CH];
   int   mrefr [N_CH];
   int   mwin;
   logic [N_CH-1:0] exp_spike;
   int   exp_data [N_CH];
   int   exp_data_s [N_CH];
   logic exp_valid;

   always #5 clk = ~clk;

   snn_lif_layer #(.CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_valid (valid),
      .i_data  (data),
      .o_spike (spike),
      .o_data  (odata),
      .o_valid (ovalid)
   );

   snn_lif_layer #(.CNT_W(CNT_W_S)) dut_sat (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_valid (valid),
      .i_data  (data),
      .o_spike (spike_s),
      .o_data  (odata_s),
      .o_valid (ovalid_s)
   );

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_CH; k++) begin
         mv[k] = 0;
         mcnt[k] = 0;
         mrefr[k] = 0;
         exp_data[k] = 0;
         exp_data_s[k] = 0;
      end
      mwin = 0;
      exp_spike = '0;
      exp_valid = 1'b0;
   endtask

   // One clock of the layer, described sample by sample
   task automatic model_step();
      int vn;
      int d;
      exp_valid = 1'b0;
      exp_spike = '0;
      if (valid) begin
         for (int k = 0; k < N_CH; k++) begin
            d = int'(data[k*DATA_W +: DATA_W]);
            if (mrefr[k] > 0) begin
               mrefr[k] = mrefr[k] - 1;
               mv[k] = 0;
            end else begin
               vn = mv[k] - (mv[k] / (1 << LEAK_SHIFT)) + d;
               if (vn > MEM_MAX) vn = MEM_MAX;
               if (vn >= THRESH) begin
                  exp_spike[k] = 1'b1;
                  mv[k] = 0;
                  mcnt[k] = mcnt[k] + 1;
                  mrefr[k] = REFRAC;
               end else begin
                  mv[k] = vn;
               end
            end
         end
         mwin = mwin + 1;
         if (mwin == WIN_LEN) begin
            exp_valid = 1'b1;
            for (int k = 0; k < N_CH; k++) begin
               exp_data[k]   = (mcnt[k] > 255) ? 255 : mcnt[k];
               exp_data_s[k] = (mcnt[k] > 7) ? 7 : mcnt[k];
               mcnt[k] = 0;
            end
            mwin = 0;
         end
      end
   endtask

   // Model follows the clock and the asynchronous reset
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else model_step();
      end
   end

   // Compare all outputs of both instances against the model every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            check_output("o_spike", int'(spike), int'(exp_spike));
            check_output("o_valid", int'(ovalid), int'(exp_valid));
            check_output("o_spike_sat", int'(spike_s), int'(exp_spike));
            check_output("o_valid_sat", int'(ovalid_s), int'(exp_valid));
            for (int k = 0; k < N_CH; k++) begin
               check_output($sformatf("o_data[%0d]", k), int'(odata[k*CNT_W +: CNT_W]), exp_data[k]);
               check_output($sformatf("o_data_sat[%0d]", k), int'(odata_s[k*CNT_W_S +: CNT_W_S]), exp_data_s[k]);
            end
         end
      end
   end

   // Drives n valid samples (optionally each followed by an idle cycle) and
   // records channel-0 spikes and o_valid per valid sample
   task automatic apply_stimulus(input int n, input int d0, input int d1, input int d2,
                                 input bit toggle, output logic [31:0] smask,
                                 output logic [31:0] vmask);
      smask = '0;
      vmask = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid = 1'b1;
         data  = {8'(d2), 8'(d1), 8'(d0)};
         @(posedge clk);
         #1;
         smask[i] = spike[0];
         vmask[i] = ovalid;
         if (toggle) begin
            @(negedge clk);
            valid = 1'b0;
            @(posedge clk);
         end
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   logic [31:0] smask;
   logic [31:0] vmask;

   initial begin
      $display("[TB] snn_lif_layer bench start");
      #1 rstn = 1'b0;
      #3;
      check_output("reset o_spike", int'(spike), 0);
      check_output("reset o_data", int'(odata), 0);
      check_output("reset o_valid", int'(ovalid), 0);
      @(negedge clk);
      #2 rstn = 1'b1;

      // mid-window asynchronous reset
      apply_stimulus(PRE_N, 40, 40, 40, 1'b0, smask, vmask);
      check_output("pre-reset spike mask", int'(smask), PRE_MASK);
      #1 rstn = 1'b0;
      #1;
      check_output("async o_spike", int'(spike), 0);
      check_output("async o_data", int'(odata), 0);
      check_output("async o_valid", int'(ovalid), 0);
      @(negedge clk);
      #2 rstn = 1'b1;

      // constant 40, full rate, one fresh window
      apply_stimulus(16, 40, 40, 40, 1'b0, smask, vmask);
      check_output("const spike mask", int'(smask), WIN_MASK);
      check_output("const o_valid position", int'(vmask), 32'h8000);
      for (int k = 0; k < N_CH; k++)
         check_output($sformatf("const count ch%0d", k), int'(odata[k*CNT_W +: CNT_W]), CONST_CNT);
      repeat (3) @(negedge clk);
      check_output("const o_data hold", int'(odata[CNT_W +: CNT_W]), CONST_CNT);

      // weak input never fires but the window still completes
      pulse_reset();
      apply_stimulus(16, 1, 1, 1, 1'b0, smask, vmask);
      check_output("weak spike mask", int'(smask), 0);
      check_output("weak o_valid position", int'(vmask), 32'h8000);
      check_output("weak o_data", int'(odata), 0);

      // mixed channels, including saturation at CNT_W=3
      pulse_reset();
      apply_stimulus(16, 0, 40, 255, 1'b0, smask, vmask);
      check_output("mixed ch0", int'(odata[0 +: CNT_W]), 0);
      check_output("mixed ch1", int'(odata[CNT_W +: CNT_W]), CONST_CNT);
      check_output("mixed ch2", int'(odata[2*CNT_W +: CNT_W]), MIX_CH2);
      check_output("sat ch1", int'(odata_s[CNT_W_S +: CNT_W_S]), CONST_CNT);
      check_output("sat ch2", int'(odata_s[2*CNT_W_S +: CNT_W_S]), MIX_CH2_S);

      // half-rate valid: idle cycles neither leak nor advance the window
      pulse_reset();
      apply_stimulus(16, 40, 40, 40, 1'b1, smask, vmask);
      check_output("toggle spike mask", int'(smask), WIN_MASK);
      check_output("toggle o_valid position", int'(vmask), 32'h8000);
      check_output("toggle count ch0", int'(odata[0 +: CNT_W]), CONST_CNT);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
